// File: rtl/mitec_dram_seq_if.sv
// Z80-side bus bundle for the DRAM sequencer.
// Optional feature macro: MITEC_WAIT_EN adds the active-low Z80 wait line.
// The Z80 wait line is named wait_n because "wait" is a reserved word.
interface mitec_dram_seq_if #(
    parameter int BANKS = 2
);
    localparam int SELW = (BANKS > 1) ? $clog2(BANKS) : 1;

    logic              mreq;
    logic              rd;
    logic              wr;
    logic              rfsh;
    logic [SELW-1:0]   bank_sel;
    logic [BANKS-1:0]  ras;
    logic [BANKS-1:0]  cas;
    logic              mux;
    logic              busy;
`ifdef MITEC_WAIT_EN
    logic              wait_n;

    modport master (output mreq, rd, wr, rfsh, bank_sel,
                    input  ras, cas, mux, busy, wait_n);
    modport slave  (input  mreq, rd, wr, rfsh, bank_sel,
                    output ras, cas, mux, busy, wait_n);
`else
    modport master (output mreq, rd, wr, rfsh, bank_sel,
                    input  ras, cas, mux, busy);
    modport slave  (input  mreq, rd, wr, rfsh, bank_sel,
                    output ras, cas, mux, busy);
`endif
endinterface

// File: rtl/mitec_dram_seq.sv
// DRAM RAS/CAS sequencer for a Z80 bus, one RAS/CAS pair per bank.
// Optional feature macro: MITEC_WAIT_EN drives a registered Z80 wait line
// that holds the CPU off while a new request waits out precharge.
module mitec_dram_seq #(
    parameter int BANKS     = 2,
    parameter int T_RAS_MUX = 1,
    parameter int T_MUX_CAS = 1,
    parameter int T_PRECH   = 2
) (
    input logic                clk,
    input logic                rst,
    mitec_dram_seq_if.slave    bus
);
    localparam int SELW = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int TMAX = (T_RAS_MUX > T_MUX_CAS) ?
                          ((T_RAS_MUX > T_PRECH) ? T_RAS_MUX : T_PRECH) :
                          ((T_MUX_CAS > T_PRECH) ? T_MUX_CAS : T_PRECH);
    localparam int CW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        COL,
        ACT,
        REF,
        PRECH
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [SELW-1:0]   bank;
    logic [SELW-1:0]   bank_next;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic [BANKS-1:0]  ras_q;
    logic [BANKS-1:0]  ras_next;
    logic [BANKS-1:0]  cas_q;
    logic [BANKS-1:0]  cas_next;
    logic              mux_q;
    logic              mux_next;
    logic              busy_q;
    logic              busy_next;
    logic              valid_req;

    // A read/write cycle to an existing bank; refresh cycles are excluded.
    assign valid_req = !bus.mreq && bus.rfsh && (!bus.rd || !bus.wr) &&
                       (int'(bus.bank_sel) < BANKS);

    // Next state, bank and timer; an abort from ROW/COL wins over the timer.
    always_comb begin
        state_next = state;
        bank_next  = bank;
        cnt_next   = (cnt != '0) ? cnt - 1'b1 : cnt;
        case (state)
            IDLE: begin
                if (!bus.mreq && !bus.rfsh) begin
                    state_next = REF;
                end else if (valid_req) begin
                    state_next = ROW;
                    bank_next  = bus.bank_sel;
                    cnt_next   = CW'(T_RAS_MUX - 1);
                end
            end
            ROW: begin
                if (bus.mreq) begin
                    state_next = PRECH;
                    cnt_next   = CW'(T_PRECH - 1);
                end else if (cnt == '0) begin
                    state_next = COL;
                    cnt_next   = CW'(T_MUX_CAS - 1);
                end
            end
            COL: begin
                if (bus.mreq) begin
                    state_next = PRECH;
                    cnt_next   = CW'(T_PRECH - 1);
                end else if (cnt == '0) begin
                    state_next = ACT;
                end
            end
            ACT, REF: begin
                if (bus.mreq) begin
                    state_next = PRECH;
                    cnt_next   = CW'(T_PRECH - 1);
                end
            end
            PRECH: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Strobe pattern for the state being entered, so outputs come off flops.
    always_comb begin
        ras_next  = '1;
        cas_next  = '1;
        mux_next  = 1'b0;
        busy_next = (state_next != IDLE);
        for (int i = 0; i < BANKS; i++) begin
            if (int'(bank_next) == i) begin
                if (state_next == ROW || state_next == COL || state_next == ACT) begin
                    ras_next[i] = 1'b0;
                end
                if (state_next == ACT) begin
                    cas_next[i] = 1'b0;
                end
            end
        end
        if (state_next == COL || state_next == ACT) begin
            mux_next = 1'b1;
        end
        if (state_next == REF) begin
            ras_next = '0;
        end
    end

    // State and output registers; reset drops every strobe without precharge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            bank   <= '0;
            cnt    <= '0;
            ras_q  <= '1;
            cas_q  <= '1;
            mux_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_next;
            bank   <= bank_next;
            cnt    <= cnt_next;
            ras_q  <= ras_next;
            cas_q  <= cas_next;
            mux_q  <= mux_next;
            busy_q <= busy_next;
        end
    end

`ifdef MITEC_WAIT_EN
    logic wait_q;

    // Hold the CPU while a valid request sits behind an ongoing precharge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= 1'b1;
        end else begin
            wait_q <= !(state_next == PRECH && valid_req);
        end
    end

    assign bus.wait_n = wait_q;
`endif

    assign bus.ras  = ras_q;
    assign bus.cas  = cas_q;
    assign bus.mux  = mux_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_mitec_dram_seq.sv
// Testbench for mitec_dram_seq: a default two-bank instance and a three-bank
// instance; expected strobes are queued when stimulus is driven and checked
// after the following clock edge. Define MITEC_WAIT_EN to cover the wait line.
module tb_mitec_dram_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mitec_dram_seq_if #(.BANKS(2)) bus2 ();
    mitec_dram_seq_if #(.BANKS(3)) bus3 ();

    mitec_dram_seq #(.BANKS(2), .T_RAS_MUX(1), .T_MUX_CAS(1), .T_PRECH(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    mitec_dram_seq #(.BANKS(3), .T_RAS_MUX(1), .T_MUX_CAS(1), .T_PRECH(2)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    typedef struct {
        logic        dut;
        logic        mreq;
        logic        rd;
        logic        wr;
        logic        rfsh;
        logic [1:0]  sel;
        logic [3:0]  ras;
        logic [3:0]  cas;
        logic        mux;
        logic        busy;
        string       name;
    } vec_t;

    typedef struct {
        logic        dut;
        logic [3:0]  ras;
        logic [3:0]  cas;
        logic        mux;
        logic        busy;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t expq[$];

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "[TB] time limit");
    end

    function automatic vec_t mk(input logic dut, input logic mreq, input logic rd,
                                input logic wr, input logic rfsh, input logic [1:0] sel,
                                input logic [3:0] ras, input logic [3:0] cas,
                                input logic mux, input logic busy, input string name);
        vec_t v;
        v.dut  = dut;  v.mreq = mreq; v.rd  = rd;  v.wr  = wr;  v.rfsh = rfsh;
        v.sel  = sel;  v.ras  = ras;  v.cas = cas; v.mux = mux; v.busy = busy;
        v.name = name;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic driveIdle2();
        bus2.mreq = 1'b1; bus2.rd = 1'b1; bus2.wr = 1'b1; bus2.rfsh = 1'b1;
        bus2.bank_sel = 1'b0;
    endtask

    task automatic driveIdle3();
        bus3.mreq = 1'b1; bus3.rd = 1'b1; bus3.wr = 1'b1; bus3.rfsh = 1'b1;
        bus3.bank_sel = 2'd0;
    endtask

    // Pop the oldest expectation and compare it with the addressed instance.
    task automatic checkOutput();
        exp_t       e;
        logic [3:0] act_ras;
        logic [3:0] act_cas;
        logic       act_mux;
        logic       act_busy;
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue, required an entry");
        end else begin
            e = expq.pop_front();
            if (e.dut == 1'b0) begin
                act_ras = {2'b00, bus2.ras}; act_cas = {2'b00, bus2.cas};
                act_mux = bus2.mux;          act_busy = bus2.busy;
            end else begin
                act_ras = {1'b0, bus3.ras};  act_cas = {1'b0, bus3.cas};
                act_mux = bus3.mux;          act_busy = bus3.busy;
            end
            checkVal({e.name, " ras"},  act_ras, e.ras);
            checkVal({e.name, " cas"},  act_cas, e.cas);
            checkVal({e.name, " mux"},  {3'b000, act_mux},  {3'b000, e.mux});
            checkVal({e.name, " busy"}, {3'b000, act_busy}, {3'b000, e.busy});
        end
    endtask

    // Drive one vector, record its expectation, let an edge sample it, then check.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        if (v.dut == 1'b0) begin
            driveIdle3();
            bus2.mreq = v.mreq; bus2.rd = v.rd; bus2.wr = v.wr; bus2.rfsh = v.rfsh;
            bus2.bank_sel = v.sel[0];
        end else begin
            driveIdle2();
            bus3.mreq = v.mreq; bus3.rd = v.rd; bus3.wr = v.wr; bus3.rfsh = v.rfsh;
            bus3.bank_sel = v.sel;
        end
        e.dut = v.dut; e.ras = v.ras; e.cas = v.cas; e.mux = v.mux; e.busy = v.busy;
        e.name = v.name;
        expq.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        driveIdle2();
        driveIdle3();

        // Two-bank vectors: mreq rd wr rfsh sel -> ras cas mux busy after the edge.
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'd1, 4'b01, 4'b11, 0, 1, "rd1 row"));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'd1, 4'b01, 4'b11, 1, 1, "rd1 col"));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'd1, 4'b01, 4'b01, 1, 1, "rd1 act"));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'd1, 4'b01, 4'b01, 1, 1, "rd1 act2"));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'd1, 4'b01, 4'b01, 1, 1, "rd1 act3"));
        vecs.push_back(mk(0, 1, 1, 1, 1, 2'd1, 4'b11, 4'b11, 0, 1, "rd1 prech"));
        vecs.push_back(mk(0, 1, 1, 1, 1, 2'd0, 4'b11, 4'b11, 0, 1, "rd1 prech2"));
        vecs.push_back(mk(0, 1, 1, 1, 1, 2'd0, 4'b11, 4'b11, 0, 0, "rd1 idle"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 2'd0, 4'b00, 4'b11, 0, 1, "ref enter"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 2'd0, 4'b00, 4'b11, 0, 1, "ref hold"));
        vecs.push_back(mk(0, 1, 1, 1, 1, 2'd0, 4'b11, 4'b11, 0, 1, "ref prech"));
        vecs.push_back(mk(0, 1, 1, 1, 1, 2'd0, 4'b11, 4'b11, 0, 1, "ref prech2"));
        vecs.push_back(mk(0, 1, 1, 1, 1, 2'd0, 4'b11, 4'b11, 0, 0, "ref idle"));
        vecs.push_back(mk(0, 0, 1, 0, 1, 2'd0, 4'b10, 4'b11, 0, 1, "wr0 row"));
        vecs.push_back(mk(0, 1, 1, 1, 1, 2'd0, 4'b11, 4'b11, 0, 1, "abort row"));
        vecs.push_back(mk(0, 1, 1, 1, 1, 2'd0, 4'b11, 4'b11, 0, 1, "abort row prech2"));
        vecs.push_back(mk(0, 1, 1, 1, 1, 2'd0, 4'b11, 4'b11, 0, 0, "abort row idle"));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'd0, 4'b10, 4'b11, 0, 1, "rd0 row"));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'd0, 4'b10, 4'b11, 1, 1, "rd0 col"));
        vecs.push_back(mk(0, 1, 1, 1, 1, 2'd0, 4'b11, 4'b11, 0, 1, "abort col"));
        vecs.push_back(mk(0, 1, 1, 1, 1, 2'd0, 4'b11, 4'b11, 0, 1, "abort col prech2"));
        vecs.push_back(mk(0, 1, 1, 1, 1, 2'd0, 4'b11, 4'b11, 0, 0, "abort col idle"));
        vecs.push_back(mk(0, 0, 1, 1, 1, 2'd1, 4'b11, 4'b11, 0, 0, "mreq no strobe"));

        // Reset state before any edge is taken out of reset.
        @(posedge clk);
        @(posedge clk);
        #1;
        checkVal("reset ras",  {2'b00, bus2.ras}, 4'b0011);
        checkVal("reset cas",  {2'b00, bus2.cas}, 4'b0011);
        checkVal("reset mux",  {3'b000, bus2.mux},  4'd0);
        checkVal("reset busy", {3'b000, bus2.busy}, 4'd0);
`ifdef MITEC_WAIT_EN
        checkVal("reset wait", {3'b000, bus2.wait_n}, 4'd1);
`endif
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // Back-to-back: a new read presented while the previous cycle precharges.
        $display("[TB] back-to-back sequence");
        applyStimulus(mk(0, 0, 0, 1, 1, 2'd0, 4'b10, 4'b11, 0, 1, "b2b row"));
        applyStimulus(mk(0, 0, 0, 1, 1, 2'd0, 4'b10, 4'b11, 1, 1, "b2b col"));
        applyStimulus(mk(0, 0, 0, 1, 1, 2'd0, 4'b10, 4'b10, 1, 1, "b2b act"));
        applyStimulus(mk(0, 1, 1, 1, 1, 2'd0, 4'b11, 4'b11, 0, 1, "b2b prech"));
        applyStimulus(mk(0, 0, 0, 1, 1, 2'd1, 4'b11, 4'b11, 0, 1, "b2b held"));
`ifdef MITEC_WAIT_EN
        checkVal("b2b wait low", {3'b000, bus2.wait_n}, 4'd0);
`endif
        applyStimulus(mk(0, 0, 0, 1, 1, 2'd1, 4'b11, 4'b11, 0, 0, "b2b idle"));
`ifdef MITEC_WAIT_EN
        checkVal("b2b wait high", {3'b000, bus2.wait_n}, 4'd1);
`endif
        applyStimulus(mk(0, 0, 0, 1, 1, 2'd1, 4'b01, 4'b11, 0, 1, "b2b accept"));
        applyStimulus(mk(0, 1, 1, 1, 1, 2'd0, 4'b11, 4'b11, 0, 1, "b2b end prech"));
        applyStimulus(mk(0, 1, 1, 1, 1, 2'd0, 4'b11, 4'b11, 0, 1, "b2b end prech2"));
        applyStimulus(mk(0, 1, 1, 1, 1, 2'd0, 4'b11, 4'b11, 0, 0, "b2b end idle"));

        // Three banks: bank 2 uses the top strobe pair, bank 3 does not exist.
        $display("[TB] three-bank sequence");
        applyStimulus(mk(1, 0, 0, 1, 1, 2'd2, 4'b011, 4'b111, 0, 1, "b3 row"));
        applyStimulus(mk(1, 0, 0, 1, 1, 2'd2, 4'b011, 4'b111, 1, 1, "b3 col"));
        applyStimulus(mk(1, 0, 0, 1, 1, 2'd2, 4'b011, 4'b011, 1, 1, "b3 act"));
        applyStimulus(mk(1, 1, 1, 1, 1, 2'd2, 4'b111, 4'b111, 0, 1, "b3 prech"));
        applyStimulus(mk(1, 1, 1, 1, 1, 2'd0, 4'b111, 4'b111, 0, 1, "b3 prech2"));
        applyStimulus(mk(1, 1, 1, 1, 1, 2'd0, 4'b111, 4'b111, 0, 0, "b3 idle"));
        applyStimulus(mk(1, 0, 0, 1, 1, 2'd3, 4'b111, 4'b111, 0, 0, "b3 bad bank"));
        applyStimulus(mk(1, 0, 1, 0, 1, 2'd3, 4'b111, 4'b111, 0, 0, "b3 bad bank wr"));

        // Reset in the middle of an active cycle must act without a clock edge.
        $display("[TB] reset during active cycle");
        applyStimulus(mk(0, 0, 0, 1, 1, 2'd1, 4'b01, 4'b11, 0, 1, "rst row"));
        applyStimulus(mk(0, 0, 0, 1, 1, 2'd1, 4'b01, 4'b11, 1, 1, "rst col"));
        applyStimulus(mk(0, 0, 0, 1, 1, 2'd1, 4'b01, 4'b01, 1, 1, "rst act"));
        #3;
        rst = 1'b1;
        #1;
        checkVal("async rst ras",  {2'b00, bus2.ras}, 4'b0011);
        checkVal("async rst cas",  {2'b00, bus2.cas}, 4'b0011);
        checkVal("async rst mux",  {3'b000, bus2.mux},  4'd0);
        checkVal("async rst busy", {3'b000, bus2.busy}, 4'd0);
        #2;
        rst = 1'b0;
        applyStimulus(mk(0, 0, 0, 1, 1, 2'd1, 4'b01, 4'b11, 0, 1, "post rst row"));
        applyStimulus(mk(0, 1, 1, 1, 1, 2'd0, 4'b11, 4'b11, 0, 1, "post rst prech"));
        applyStimulus(mk(0, 1, 1, 1, 1, 2'd0, 4'b11, 4'b11, 0, 1, "post rst prech2"));
        applyStimulus(mk(0, 1, 1, 1, 1, 2'd0, 4'b11, 4'b11, 0, 0, "post rst idle"));

        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d left, required 0", expq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
